req_fifo_mc: RTL and testbench

Multi-channel successor to the endpoint requestor FIFO. It holds NUM_CH independent FIFOs of WIDTH-bit packet metadata, all written from the CRC-checked receive path. A memory-mapped bus peripheral provides peek/pop/flush/count per channel, sticky write-1-to-clear error flags, and a per-channel watermark. A maskable interrupt lets endpoint software service channels without polling.

---
 rtl/req_fifo_mc_if.sv | 29 ++
 rtl/req_fifo_mc.sv | 250 +++++++++++++++++++++++++
 tb/tb_req_fifo_mc.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/req_fifo_mc_if.sv
// -----------------------------------------------------------------------------
// bus_protocol_if
//   Single-cycle memory-mapped bus shared by the endpoint peripherals.
//   Signals:
//     ren, wen      read / write strobes (controller -> peripheral)
//     addr, wdata   32-bit byte address and write data
//     rdata         32-bit read data, combinational in the access cycle
//     error         access rejected (unmapped, illegal direction, ren&wen)
//     request_stall peripheral needs more cycles (never used here)
// -----------------------------------------------------------------------------
interface bus_protocol_if;
  logic        ren;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        error;
  logic        request_stall;

  modport peripheral_vital (
    input  ren, wen, addr, wdata,
    output rdata, error, request_stall
  );

  modport controller (
    output ren, wen, addr, wdata,
    input  rdata, error, request_stall
  );
endinterface

// File: rtl/req_fifo_mc.sv
// -----------------------------------------------------------------------------
// req_fifo_mc
//   NUM_CH independent FIFOs of WIDTH-bit packet metadata, all filled from the
//   CRC-checked receive path and drained by software through a bus
//   peripheral (count / status / peek / pop / clear / watermark per channel,
//   plus a maskable interrupt).
//
// Ports:
//   clk          system clock
//   n_rst        asynchronous active-low reset
//   push_valid   one metadata push this cycle
//   push_ch      destination channel (values >= NUM_CH are dropped)
//   push_data    metadata to enqueue
//   overflow     per-channel sticky overrun flag
//   packet_recv  per-channel non-empty
//   irq          OR over channels of (irq_pend & irq_en)
//   bus_if       memory-mapped register access (single cycle, never stalls)
//
// Register map (channel c at c*0x20):
//   +0x00 COUNT  RO   +0x04 STATUS W1C[1:0]   +0x08 PEEK RO
//   +0x0C POP    RO   +0x10 CLEAR  WO         +0x14 WMARK RW
//   0x100 IRQ_PEND RO                         0x104 IRQ_EN RW
// -----------------------------------------------------------------------------
module req_fifo_mc #(
  parameter  int WIDTH  = 7,
  parameter  int DEPTH  = 16,
  parameter  int NUM_CH = 4,
  localparam int PCW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  push_valid,
  input  logic [PCW-1:0]        push_ch,
  input  logic [WIDTH-1:0]      push_data,
  output logic [NUM_CH-1:0]     overflow,
  output logic [NUM_CH-1:0]     packet_recv,
  output logic                  irq,
  bus_protocol_if.peripheral_vital bus_if
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [31:0] ADDR_IRQ_PEND = 32'h0000_0100;
  localparam logic [31:0] ADDR_IRQ_EN   = 32'h0000_0104;

  // Word offset (addr[4:2]) inside a channel's register window.
  typedef enum logic [2:0] {
    REG_COUNT  = 3'd0,
    REG_STATUS = 3'd1,
    REG_PEEK   = 3'd2,
    REG_POP    = 3'd3,
    REG_CLEAR  = 3'd4,
    REG_WMARK  = 3'd5
  } reg_off_e;

  // ---------------------------------------------------------------- state
  logic [WIDTH-1:0]  r_mem    [NUM_CH][DEPTH];
  logic [AW-1:0]     r_rd_ptr [NUM_CH];
  logic [AW-1:0]     r_wr_ptr [NUM_CH];
  logic [CW-1:0]     r_count  [NUM_CH];
  logic [CW-1:0]     r_wmark  [NUM_CH];
  logic [NUM_CH-1:0] r_ovr;
  logic [NUM_CH-1:0] r_udr;
  logic [NUM_CH-1:0] r_irq_en;

  // ---------------------------------------------------------- derived view
  logic [NUM_CH-1:0] w_full, w_empty, w_at_wmark, w_irq_pend, w_push_hit;
  logic [WIDTH-1:0]  w_head [NUM_CH];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_full[c]     = (r_count[c] == CW'(DEPTH));
      w_empty[c]    = (r_count[c] == '0);
      w_at_wmark[c] = (r_count[c] >= r_wmark[c]);
      w_irq_pend[c] = w_at_wmark[c] | r_ovr[c];
      w_head[c]     = w_empty[c] ? '0 : r_mem[c][r_rd_ptr[c]];
      w_push_hit[c] = push_valid && (push_ch == PCW'(c));
    end
  end

  // ------------------------------------------------------------ bus decode
  reg_off_e          w_off;
  logic              w_access, w_err, w_irq_en_we;
  logic [31:0]       w_rdata;
  logic [NUM_CH-1:0] w_ch_hit, w_pop, w_clear, w_w1c_ovr, w_w1c_udr, w_wmark_we;
  logic [CW-1:0]     w_sel_count, w_sel_wmark, w_wmark_wdata;
  logic [WIDTH-1:0]  w_sel_head;
  logic [4:0]        w_sel_status;
  logic              w_unused;

  assign w_off         = reg_off_e'(bus_if.addr[4:2]);
  assign w_access      = n_rst && (bus_if.ren || bus_if.wen);
  // A watermark of 0 would hold the interrupt permanently; store it as 1.
  assign w_wmark_wdata = (bus_if.wdata[AW:0] == '0) ? CW'(1) : bus_if.wdata[AW:0];
  assign w_unused      = ^bus_if.wdata;

  // NOTE: every variable gets a default at the top of the block so that no
  // path through the decode leaves one unassigned and infers a latch.
  always_comb begin
    w_err        = 1'b0;
    w_rdata      = '0;
    w_irq_en_we  = 1'b0;
    w_ch_hit     = '0;
    w_pop        = '0;
    w_clear      = '0;
    w_w1c_ovr    = '0;
    w_w1c_udr    = '0;
    w_wmark_we   = '0;
    w_sel_count  = '0;
    w_sel_wmark  = '0;
    w_sel_head   = '0;
    w_sel_status = '0;

    // Channel windows occupy 0x000-0x0FF; a hit only exists for c < NUM_CH.
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus_if.addr[31:8] == '0 && bus_if.addr[7:5] == 3'(c)) begin
        w_ch_hit[c]  = 1'b1;
        w_sel_count  = r_count[c];
        w_sel_wmark  = r_wmark[c];
        w_sel_head   = w_head[c];
        w_sel_status = {w_at_wmark[c], w_full[c], w_empty[c], r_udr[c], r_ovr[c]};
      end
    end

    if (w_access) begin
      if (bus_if.ren && bus_if.wen) begin
        w_err = 1'b1;
      end else if (bus_if.addr[1:0] != 2'b00) begin
        w_err = 1'b1;
      end else if (bus_if.addr == ADDR_IRQ_PEND) begin
        if (bus_if.wen) w_err = 1'b1;
        else            w_rdata = 32'(w_irq_pend);
      end else if (bus_if.addr == ADDR_IRQ_EN) begin
        if (bus_if.wen) w_irq_en_we = 1'b1;
        else            w_rdata = 32'(r_irq_en);
      end else if (w_ch_hit == '0) begin
        w_err = 1'b1;
      end else begin
        case (w_off)
          REG_COUNT: begin
            if (bus_if.wen) w_err = 1'b1;
            else            w_rdata = 32'(w_sel_count);
          end
          REG_STATUS: begin
            if (bus_if.ren) begin
              w_rdata = 32'(w_sel_status);
            end else begin
              w_w1c_ovr = w_ch_hit & {NUM_CH{bus_if.wdata[0]}};
              w_w1c_udr = w_ch_hit & {NUM_CH{bus_if.wdata[1]}};
            end
          end
          REG_PEEK: begin
            if (bus_if.wen) w_err = 1'b1;
            else            w_rdata = 32'(w_sel_head);
          end
          REG_POP: begin
            if (bus_if.wen) begin
              w_err = 1'b1;
            end else begin
              w_rdata = 32'(w_sel_head);
              w_pop   = w_ch_hit;
            end
          end
          REG_CLEAR: begin
            if (bus_if.ren) w_err = 1'b1;
            else            w_clear = w_ch_hit;
          end
          REG_WMARK: begin
            if (bus_if.ren) w_rdata = 32'(w_sel_wmark);
            else            w_wmark_we = w_ch_hit;
          end
          default: w_err = 1'b1;
        endcase
      end
    end
  end

  assign bus_if.rdata         = w_rdata;
  assign bus_if.error         = w_err;
  assign bus_if.request_stall = 1'b0;

  // ------------------------------------------------------- push/pop arbitration
  // A pop on a full FIFO frees the slot the same-cycle push lands in, so the
  // push is accepted without overrun. CLEAR discards any same-cycle push.
  logic [NUM_CH-1:0] w_do_pop, w_do_push, w_set_ovr;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_do_pop[c]  = w_pop[c] && !w_empty[c];
      w_do_push[c] = w_push_hit[c] && (!w_full[c] || w_do_pop[c]) && !w_clear[c];
      w_set_ovr[c] = w_push_hit[c] && w_full[c] && !w_do_pop[c] && !w_clear[c];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_rd_ptr[c] <= '0;
        r_wr_ptr[c] <= '0;
        r_count[c]  <= '0;
        r_wmark[c]  <= CW'(1);
      end
      r_ovr    <= '0;
      r_udr    <= '0;
      r_irq_en <= '0;
    end else begin
      if (w_irq_en_we) r_irq_en <= bus_if.wdata[NUM_CH-1:0];
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_clear[c]) begin
          r_rd_ptr[c] <= '0;
          r_wr_ptr[c] <= '0;
          r_count[c]  <= '0;
          r_ovr[c]    <= 1'b0;
          r_udr[c]    <= 1'b0;
        end else begin
          if (w_do_pop[c])  r_rd_ptr[c] <= r_rd_ptr[c] + AW'(1);
          if (w_do_push[c]) r_wr_ptr[c] <= r_wr_ptr[c] + AW'(1);
          if (w_do_push[c] && !w_do_pop[c])      r_count[c] <= r_count[c] + CW'(1);
          else if (w_do_pop[c] && !w_do_push[c]) r_count[c] <= r_count[c] - CW'(1);
          // Set has priority over a same-cycle write-1-to-clear.
          if (w_set_ovr[c])      r_ovr[c] <= 1'b1;
          else if (w_w1c_ovr[c]) r_ovr[c] <= 1'b0;
          if (w_pop[c] && w_empty[c]) r_udr[c] <= 1'b1;
          else if (w_w1c_udr[c])      r_udr[c] <= 1'b0;
        end
        if (w_wmark_we[c]) r_wmark[c] <= w_wmark_wdata;
      end
    end
  end

  // NOTE: the entry storage is not reset; the pointers and count define which
  // entries are valid, and PEEK/POP return 0 whenever the count is zero.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_do_push[c]) r_mem[c][r_wr_ptr[c]] <= push_data;
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) packet_recv[c] = !w_empty[c];
  end

  assign overflow = r_ovr;
  assign irq      = |(w_irq_pend & r_irq_en);

endmodule

// File: tb/tb_req_fifo_mc.sv
module tb_req_fifo_mc;
  localparam int WIDTH  = 7;
  localparam int DEPTH  = 16;
  localparam int NUM_CH = 4;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              push_valid;
  logic [1:0]        push_ch;
  logic [WIDTH-1:0]  push_data;
  logic [NUM_CH-1:0] overflow;
  logic [NUM_CH-1:0] packet_recv;
  logic              irq;

  bus_protocol_if bus ();

  req_fifo_mc #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .push_valid  (push_valid),
    .push_ch     (push_ch),
    .push_data   (push_data),
    .overflow    (overflow),
    .packet_recv (packet_recv),
    .irq         (irq),
    .bus_if      (bus)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------ reference model
  typedef enum {K_NONE, K_POP, K_CLEAR, K_W1C, K_WMARK, K_IRQEN} kind_e;

  logic [WIDTH-1:0]  mq [NUM_CH][$];
  bit                m_ovr [NUM_CH];
  bit                m_udr [NUM_CH];
  int                m_wm  [NUM_CH];
  logic [NUM_CH-1:0] m_irq_en;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]       last_rdata;
  logic              last_err;
  logic [NUM_CH-1:0] last_ovf, last_recv;
  logic              last_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      mq[c].delete();
      m_ovr[c] = 0;
      m_udr[c] = 0;
      m_wm[c]  = 1;
    end
    m_irq_en = '0;
  endfunction

  function automatic logic [NUM_CH-1:0] m_pend();
    logic [NUM_CH-1:0] p;
    for (int c = 0; c < NUM_CH; c++) p[c] = (mq[c].size() >= m_wm[c]) || m_ovr[c];
    return p;
  endfunction

  function automatic logic [31:0] m_head(input int c);
    return (mq[c].size() > 0) ? 32'(mq[c][0]) : 32'd0;
  endfunction

  // Decode one bus access against the register map; returns response and
  // the side effect to apply at the clock edge.
  function automatic void m_access(input logic rn, input logic wn, input logic [31:0] a,
                                   output logic err, output logic [31:0] rd,
                                   output kind_e k, output int ch);
    int off;
    err = 0; rd = 0; k = K_NONE; ch = 0;
    if (!rn && !wn) return;
    if (rn && wn) begin err = 1; return; end
    if (a == 32'h100) begin
      if (wn) err = 1; else rd = 32'(m_pend());
      return;
    end
    if (a == 32'h104) begin
      if (wn) k = K_IRQEN; else rd = 32'(m_irq_en);
      return;
    end
    if (a >= 32'h100 || a[1:0] != 2'b00) begin err = 1; return; end
    ch  = int'(a) / 32;
    off = int'(a) % 32;
    if (ch >= NUM_CH) begin err = 1; return; end
    case (off)
      0:  if (wn) err = 1; else rd = mq[ch].size();
      4:  if (wn) k = K_W1C;
          else rd = {27'd0, mq[ch].size() >= m_wm[ch], mq[ch].size() == DEPTH,
                     mq[ch].size() == 0, m_udr[ch], m_ovr[ch]};
      8:  if (wn) err = 1; else rd = m_head(ch);
      12: if (wn) err = 1; else begin rd = m_head(ch); k = K_POP; end
      16: if (rn) err = 1; else k = K_CLEAR;
      20: if (rn) rd = m_wm[ch]; else k = K_WMARK;
      default: err = 1;
    endcase
  endfunction

  function automatic void m_update(input logic pv, input int pch, input logic [WIDTH-1:0] pd,
                                   input kind_e k, input int ch, input logic [31:0] wd);
    int v;
    for (int c = 0; c < NUM_CH; c++) begin
      bit set_ovr;
      set_ovr = 0;
      if (k == K_CLEAR && ch == c) begin
        mq[c].delete();
        m_ovr[c] = 0;
        m_udr[c] = 0;
        continue;
      end
      if (k == K_POP && ch == c) begin
        if (mq[c].size() > 0) void'(mq[c].pop_front());
        else m_udr[c] = 1;
      end
      if (pv && pch == c) begin
        if (mq[c].size() < DEPTH) mq[c].push_back(pd);
        else begin m_ovr[c] = 1; set_ovr = 1; end
      end
      if (k == K_W1C && ch == c) begin
        if (wd[0] && !set_ovr) m_ovr[c] = 0;
        if (wd[1]) m_udr[c] = 0;
      end
    end
    if (k == K_WMARK) begin
      v = int'(wd) % (2 * DEPTH);
      m_wm[ch] = (v == 0) ? 1 : v;
    end
    if (k == K_IRQEN) m_irq_en = wd[NUM_CH-1:0];
  endfunction

  // One clock cycle: drive after the falling edge, compare before the rising
  // edge, advance the model on the rising edge.
  task automatic step(input logic pv, input int pch, input logic [WIDTH-1:0] pd,
                      input logic rn, input logic wn, input logic [31:0] a,
                      input logic [31:0] wd, input string tag);
    logic        e_err;
    logic [31:0] e_rd;
    kind_e       k;
    int          ch;
    @(negedge clk);
    push_valid = pv;
    push_ch    = 2'(pch);
    push_data  = pd;
    bus.ren    = rn;
    bus.wen    = wn;
    bus.addr   = a;
    bus.wdata  = wd;
    #1;
    m_access(rn, wn, a, e_err, e_rd, k, ch);
    check($sformatf("%s_err@%0h", tag, a), 32'(bus.error), 32'(e_err));
    check($sformatf("%s_rdata@%0h", tag, a), bus.rdata, e_rd);
    check($sformatf("%s_stall", tag), 32'(bus.request_stall), 32'd0);
    check($sformatf("%s_overflow", tag), 32'(overflow), 32'({m_ovr[3], m_ovr[2], m_ovr[1], m_ovr[0]}));
    check($sformatf("%s_recv", tag), 32'(packet_recv),
          32'({mq[3].size() != 0, mq[2].size() != 0, mq[1].size() != 0, mq[0].size() != 0}));
    check($sformatf("%s_irq", tag), 32'(irq), 32'(|(m_pend() & m_irq_en)));
    last_rdata = bus.rdata;
    last_err   = bus.error;
    last_ovf   = overflow;
    last_recv  = packet_recv;
    last_irq   = irq;
    @(posedge clk);
    m_update(pv, pch, pd, k, ch, e_err ? 32'd0 : wd);
    if (e_err) begin
      // An errored access has no side effect; undo any decoded action.
    end
  endtask

  task automatic push(input int ch, input logic [WIDTH-1:0] d);
    step(1'b1, ch, d, 1'b0, 1'b0, 32'd0, 32'd0, "push");
  endtask
  task automatic rd(input logic [31:0] a);
    step(1'b0, 0, '0, 1'b1, 1'b0, a, 32'd0, "rd");
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 0, '0, 1'b0, 1'b1, a, d, "wr");
  endtask
  task automatic idle();
    step(1'b0, 0, '0, 1'b0, 1'b0, 32'd0, 32'd0, "idle");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_rst = 1'b0; push_valid = 1'b0; push_ch = '0; push_data = '0;
    bus.ren = 1'b0; bus.wen = 1'b0; bus.addr = '0; bus.wdata = '0;
    m_reset();
    #3;
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_recv", 32'(packet_recv), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_err", 32'(bus.error), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    // Basic ordering on ch2.
    push(2, 7'h15);
    push(2, 7'h2A);
    rd(32'h40);  check("tp1_count", last_rdata, 32'd2);
                 check("tp1_recv", 32'(last_recv), 32'h4);
    rd(32'h48);  check("tp1_peek0", last_rdata, 32'h15);
    rd(32'h48);  check("tp1_peek1", last_rdata, 32'h15);
    rd(32'h4C);  check("tp1_pop0", last_rdata, 32'h15);
    rd(32'h4C);  check("tp1_pop1", last_rdata, 32'h2A);
    rd(32'h40);  check("tp1_count_end", last_rdata, 32'd0);
                 check("tp1_recv_end", 32'(last_recv), 32'd0);

    // Overrun on ch0: 17 pushes, the last one lost.
    for (int i = 0; i < 17; i++) push(0, 7'(i));
    rd(32'h00);  check("tp2_count", last_rdata, 32'd16);
                 check("tp2_ovf", 32'(last_ovf[0]), 32'd1);
    rd(32'h04);  check("tp2_full", 32'(last_rdata[3]), 32'd1);
    for (int i = 0; i < 16; i++) begin
      rd(32'h0C);
      check($sformatf("tp2_pop%0d", i), last_rdata, 32'(i));
    end
    wr(32'h04, 32'h1);
    idle();      check("tp2_ovf_clr", 32'(last_ovf[0]), 32'd0);

    // Underrun on ch1, then push+pop on empty.
    rd(32'h2C);  check("tp3_pop_empty", last_rdata, 32'd0);
    rd(32'h24);  check("tp3_udr", 32'(last_rdata[1]), 32'd1);
    wr(32'h24, 32'h2);
    step(1'b1, 1, 7'h33, 1'b1, 1'b0, 32'h2C, 32'd0, "tp3_pp");
    check("tp3_pp_rdata", last_rdata, 32'd0);
    rd(32'h24);  check("tp3_udr2", 32'(last_rdata[1]), 32'd1);
    rd(32'h20);  check("tp3_count", last_rdata, 32'd1);
    wr(32'h30, 32'hDEAD);

    // Full ch3, push + pop in the same cycle.
    for (int i = 0; i < 16; i++) push(3, 7'(8'h40 + i));
    step(1'b1, 3, 7'h7F, 1'b1, 1'b0, 32'h6C, 32'd0, "tp4_pp");
    check("tp4_pp_rdata", last_rdata, 32'h40);
    rd(32'h60);  check("tp4_count", last_rdata, 32'd16);
    rd(32'h64);  check("tp4_no_ovr", 32'(last_rdata[0]), 32'd0);
    for (int i = 0; i < 16; i++) rd(32'h6C);
    check("tp4_last", last_rdata, 32'h7F);

    // Watermark interrupt on ch1.
    wr(32'h34, 32'd4);
    wr(32'h104, 32'h2);
    for (int i = 0; i < 3; i++) push(1, 7'(i + 1));
    idle();      check("tp5_irq_lo", 32'(last_irq), 32'd0);
    push(1, 7'h4);
    idle();      check("tp5_irq_hi", 32'(last_irq), 32'd1);
    rd(32'h100); check("tp5_pend", last_rdata, 32'h2);
    rd(32'h2C);
    idle();      check("tp5_irq_pop", 32'(last_irq), 32'd0);

    // Bus errors.
    rd(32'h18);  check("tp6_err18", 32'(last_err), 32'd1);
    rd(32'h90);  check("tp6_err90", 32'(last_err), 32'd1);
    rd(32'h10);  check("tp6_err10", 32'(last_err), 32'd1);
    wr(32'h00, 32'h5);  check("tp6_err00w", 32'(last_err), 32'd1);
    step(1'b0, 0, '0, 1'b1, 1'b1, 32'h20, 32'd0, "tp6_rw");
    check("tp6_err_rw", 32'(last_err), 32'd1);
    wr(32'h14, 32'd0);
    rd(32'h14);  check("tp6_wm0", last_rdata, 32'd1);

    // Asynchronous reset mid-stream.
    wr(32'h104, 32'hF);
    for (int i = 0; i < 5; i++) push(0, 7'(i + 9));
    rd(32'h00);  check("tp7_count_pre", last_rdata, 32'd5);
                 check("tp7_irq_pre", 32'(last_irq), 32'd1);
    @(negedge clk);
    push_valid = 1'b1; push_ch = 2'd0; push_data = 7'h55;
    bus.ren = 1'b1; bus.wen = 1'b0; bus.addr = 32'h00;
    #2;
    n_rst = 1'b0;
    #1;
    m_reset();
    check("tp7_rst_rdata", bus.rdata, 32'd0);
    check("tp7_rst_recv", 32'(packet_recv), 32'd0);
    check("tp7_rst_irq", 32'(irq), 32'd0);
    bus.addr = 32'h18;
    #1;
    check("tp7_rst_err", 32'(bus.error), 32'd0);
    @(negedge clk);
    push_valid = 1'b0; bus.ren = 1'b0;
    n_rst = 1'b1;
    rd(32'h00);  check("tp7_count", last_rdata, 32'd0);
    rd(32'h14);  check("tp7_wmark", last_rdata, 32'd1);
                 check("tp7_irq", 32'(last_irq), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic        pv, rn, wn;
      int          pch, ch;
      logic [31:0] a, wd;
      pv  = ($urandom_range(0, 9) < 6);
      pch = $urandom_range(0, NUM_CH - 1);
      ch  = $urandom_range(0, NUM_CH - 1);
      rn = 1'b0; wn = 1'b0; a = 32'(ch * 32); wd = 32'd0;
      case ($urandom_range(0, 11))
        0, 1, 2: begin rn = 1'b1; a += 32'h0C; end
        3:       begin rn = 1'b1; a += 32'h08; end
        4:       begin rn = 1'b1; end
        5:       begin rn = 1'b1; a += 32'h04; end
        6:       begin wn = 1'b1; a += 32'h04; wd = $urandom_range(0, 3); end
        7:       if ($urandom_range(0, 3) == 0) begin wn = 1'b1; a += 32'h10; end
        8:       begin wn = 1'b1; a += 32'h14; wd = $urandom_range(0, 20); end
        9:       begin rn = 1'b1; a = 32'h100; end
        10:      begin wn = 1'b1; a = 32'h104; wd = $urandom_range(0, 15); end
        default: begin rn = 1'b1; wn = ($urandom_range(0, 1) == 1); a += 32'h18; end
      endcase
      step(pv, pch, 7'($urandom), rn, wn, a, wd, "rnd");
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
